double_eye_imgbuf: RTL and testbench

Dual-image pixel buffer that sits on the memory side of the disparity calculator's `address_f`/`fdata` and `address_g`/`gdata` read ports. It accepts a streamed left/right pixel pair per handshake and fills two on-chip RAMs. It then freezes and serves one-cycle-latency reads from the calculator until released. It is the responder for the calculator's address-driven read interface.

---
 rtl/double_eye_imgbuf.sv | 129 ++++++++++++
 tb/tb_double_eye_imgbuf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/double_eye_imgbuf.sv
// double_eye_imgbuf: dual-image pixel buffer for the disparity calculator.
// Loads left/right pixel pairs into two RAMs. It then freezes and serves
// independent one-cycle-latency reads until the consumer releases it.
// Optional build macro: IMGBUF_OOB_ZERO_EN. When it is defined, a read
// address at or beyond frame_len returns 0 on that port.
module double_eye_imgbuf #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int PIX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_f,
  input  logic [PIX_W-1:0]  in_g,
  input  logic              in_last,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  input  logic              calc_done,
  input  logic [ADDR_W-1:0] address_f,
  input  logic [ADDR_W-1:0] address_g,
  output logic [PIX_W-1:0]  fdata,
  output logic [PIX_W-1:0]  gdata
);

  localparam int PTR_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] frame_len_q, frame_len_d;
  logic [PIX_W-1:0] fdata_q, fdata_d;
  logic [PIX_W-1:0] gdata_q, gdata_d;
  logic             wr_en;

  logic [PIX_W-1:0] ram_f [DEPTH];
  logic [PIX_W-1:0] ram_g [DEPTH];

  assign in_ready    = (state_q == S_LOAD);
  assign frame_ready = (state_q == S_SERVE);
  assign frame_len   = frame_len_q;
  assign fdata       = fdata_q;
  assign gdata       = gdata_q;

  // Next-state, write pointer, frame length and read-data selection.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    frame_len_d = frame_len_q;
    wr_en       = 1'b0;
    fdata_d     = '0;
    gdata_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          // A full buffer ends the frame even without in_last.
          if (in_last || (wptr_q == LAST_PTR)) begin
            state_d     = S_SERVE;
            frame_len_d = wptr_q + 1'b1;
          end
        end
      end
      S_SERVE: begin
        if (calc_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reads are only meaningful while frozen; otherwise the outputs settle to 0.
    if (state_q == S_SERVE) begin
      fdata_d = ram_f[address_f];
      gdata_d = ram_g[address_g];
`ifdef IMGBUF_OOB_ZERO_EN
      if ({1'b0, address_f} >= frame_len_q) begin
        fdata_d = '0;
      end
      if ({1'b0, address_g} >= frame_len_q) begin
        gdata_d = '0;
      end
`endif
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      frame_len_q <= '0;
      fdata_q     <= '0;
      gdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      frame_len_q <= frame_len_d;
      fdata_q     <= fdata_d;
      gdata_q     <= gdata_d;
    end
  end

  // Image RAM writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_f[wptr_q[ADDR_W-1:0]] <= in_f;
      ram_g[wptr_q[ADDR_W-1:0]] <= in_g;
    end
  end

endmodule

// File: tb/tb_double_eye_imgbuf.sv
// Testbench for double_eye_imgbuf: directed load/serve scenarios, with a
// frame-level reference model compared against the outputs every cycle.
module tb_double_eye_imgbuf;

  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;
  localparam int PIX_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_f;
  logic [PIX_W-1:0]  in_g;
  logic              in_last;
  logic              frame_ready;
  logic [ADDR_W:0]   frame_len;
  logic              calc_done;
  logic [ADDR_W-1:0] address_f;
  logic [ADDR_W-1:0] address_g;
  logic [PIX_W-1:0]  fdata;
  logic [PIX_W-1:0]  gdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  double_eye_imgbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_f(in_f), .in_g(in_g), .in_last(in_last),
    .frame_ready(frame_ready), .frame_len(frame_len),
    .calc_done(calc_done),
    .address_f(address_f), .address_g(address_g),
    .fdata(fdata), .gdata(gdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffer phase (0 idle, 1 loading, 2 frozen), pair count,
  // stored images with a "was ever written" flag, and expected read data.
  int      m_phase = 0;
  int      m_count = 0;
  int      m_len   = 0;
  int      m_f [DEPTH];
  int      m_g [DEPTH];
  bit      m_known [DEPTH];
  int      e_f = 0, e_g = 0;
  bit      e_fk = 1'b1, e_gk = 1'b1;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_count = 0; m_len = 0;
      e_f = 0; e_g = 0; e_fk = 1'b1; e_gk = 1'b1;
    end else begin
      if (m_phase == 2) begin
        bit oob_f, oob_g;
        oob_f = 1'b0; oob_g = 1'b0;
`ifdef IMGBUF_OOB_ZERO_EN
        oob_f = (int'(address_f) >= m_len);
        oob_g = (int'(address_g) >= m_len);
`endif
        e_f  = oob_f ? 0 : m_f[address_f];
        e_fk = oob_f ? 1'b1 : m_known[address_f];
        e_g  = oob_g ? 0 : m_g[address_g];
        e_gk = oob_g ? 1'b1 : m_known[address_g];
      end else begin
        e_f = 0; e_g = 0; e_fk = 1'b1; e_gk = 1'b1;
      end
      if (m_phase == 0 && start) begin
        m_phase = 1; m_count = 0;
      end else if (m_phase == 1 && in_valid) begin
        m_f[m_count] = int'(in_f);
        m_g[m_count] = int'(in_g);
        m_known[m_count] = 1'b1;
        m_count++;
        if (in_last || m_count == DEPTH) begin
          m_len = m_count;
          m_phase = 2;
        end
      end else if (m_phase == 2 && calc_done) begin
        m_phase = 0;
      end
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", in_ready, (m_phase == 1));
      chk("m_frame_ready", frame_ready, (m_phase == 2));
      chk("m_frame_len", frame_len, m_len);
      if (e_fk) chk("m_fdata", fdata, e_f);
      if (e_gk) chk("m_gdata", gdata, e_g);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pair(input int f, input int g, input bit last);
    in_valid = 1'b1; in_f = PIX_W'(f); in_g = PIX_W'(g); in_last = last;
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_done();
    calc_done = 1'b1; cyc(); calc_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_f = '0; in_g = '0;
    in_last = 1'b0; calc_done = 1'b0; address_f = '0; address_g = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_fdata", fdata, 0);
    chk("rst_gdata", gdata, 0);
    reset = 1'b1;
    cyc();

    // Basic 4-pair frame.
    pulse_start();
    chk("t1_in_ready", in_ready, 1);
    pair(1, 5, 0); pair(2, 6, 0); pair(3, 7, 0); pair(4, 0, 1);
    chk("t1_frame_ready", frame_ready, 1);
    chk("t1_frame_len", frame_len, 4);
    chk("t1_in_ready_low", in_ready, 0);
    address_f = 11'd2; address_g = 11'd0;
    cyc();
    chk("t1_fdata", fdata, 3);
    chk("t1_gdata", gdata, 5);

    // Start inside SERVE is ignored; calc_done releases with one trailing read.
    pulse_start();
    chk("t4_start_ignored", frame_ready, 1);
    pulse_done();
    chk("t4_frame_ready", frame_ready, 0);
    chk("t4_last_read", fdata, 3);
    cyc();
    chk("t4_fdata_zero", fdata, 0);
    chk("t4_gdata_zero", gdata, 0);
    chk("t4_len_kept", frame_len, 4);
    pulse_done();
    chk("t4_done_idle_ignored", in_ready, 0);

    // Full-buffer load without in_last; extra pairs are refused.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_f = PIX_W'(i % 8); in_g = PIX_W'((i * 3) % 8);
      cyc();
    end
    chk("t2_frame_len", frame_len, 2048);
    chk("t2_frame_ready", frame_ready, 1);
    in_f = 3'd6; in_g = 3'd6;
    for (int i = 0; i < 3; i++) begin
      chk("t2_in_ready_low", in_ready, 0);
      cyc();
    end
    in_valid = 1'b0;
    address_f = 11'd0; address_g = 11'd1;
    cyc();
    chk("t2_fdata0", fdata, 0);
    chk("t2_gdata1", gdata, 3);
    address_f = 11'd2047; address_g = 11'd2047;
    cyc();
    chk("t2_fdata2047", fdata, 7);
    chk("t2_gdata2047", gdata, 5);
    pulse_done();

    // Gapped input: one pair every third cycle.
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      pair(7 - i, i + 1, (i == 4));
      if (i != 4) begin cyc(); cyc(); end
    end
    chk("t3_frame_len", frame_len, 5);
    for (int a = 0; a < 5; a++) begin
      address_f = ADDR_W'(a); address_g = ADDR_W'(a);
      cyc();
    end
    address_f = 11'd3; address_g = 11'd3;
    cyc();
    chk("t3_fdata3", fdata, 4);
    chk("t3_gdata3", gdata, 4);

    // Out-of-range read: stale data unless the zeroing option is built in.
    address_f = 11'd10; address_g = 11'd2047;
    cyc();
`ifdef IMGBUF_OOB_ZERO_EN
    chk("t6_oob_f", fdata, 0);
    chk("t6_oob_g", gdata, 0);
`else
    chk("t6_oob_f", fdata, 2);
    chk("t6_oob_g", gdata, 5);
`endif
    pulse_done();

    // Reset partway through a load, then a clean reload.
    pulse_start();
    pair(1, 1, 0); pair(2, 2, 0); pair(3, 3, 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_frame_ready", frame_ready, 0);
    chk("t5_frame_len", frame_len, 0);
    cyc();
    pulse_start();
    pair(5, 2, 0); pair(6, 3, 0); pair(7, 4, 0); pair(0, 1, 1);
    chk("t5_reload_len", frame_len, 4);
    address_f = 11'd2; address_g = 11'd3;
    cyc();
    chk("t5_reload_f", fdata, 7);
    chk("t5_reload_g", gdata, 1);
    pulse_done();
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
